arm_alu_pipe: RTL and testbench

Pipelined, width-parametrised ARM-style ALU with a valid/ready handshake on both sides and an architectural NZCV flag register. Carry-in for ADC/SBC/RSC comes from that register. The block sits between operand fetch and writeback in the datapath. It keeps the established 4-bit opcode map and adds ARM-correct C/V semantics for all arithmetic ops, conditional flag update (S-bit), backpressure, and an optional iterative multiply.

---
 rtl/arm_alu_pkg.sv | 53 +++++
 rtl/arm_alu_core.sv | 70 +++++++
 rtl/arm_alu_pipe.sv | 149 ++++++++++++++
 tb/tb_arm_alu_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_alu_pkg.sv
// ---------------------------------------------------------------------------
// arm_alu_pkg
// Shared definitions for the ARM-style pipelined ALU:
//   - alu_op_e : 4-bit opcode map
//   - FLAG_N/Z/C/V : bit positions inside a {N,Z,C,V} flag vector
//   - is_arith / uses_carry / is_defined : opcode decode helpers
// Configuration macro: ARM_ALU_MUL_EN (opcode 1101 becomes a defined MUL).
// ---------------------------------------------------------------------------
package arm_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADC  = 4'h1,
        OP_SUB  = 4'h2,
        OP_SBC  = 4'h3,
        OP_RSB  = 4'h4,
        OP_RSC  = 4'h5,
        OP_AND  = 4'h6,
        OP_ORR  = 4'h7,
        OP_EOR  = 4'h8,
        OP_MOVA = 4'h9,
        OP_MOVB = 4'hA,
        OP_MVN  = 4'hB,
        OP_BIC  = 4'hC,
        OP_MUL  = 4'hD,
        OP_UND0 = 4'hE,
        OP_UND1 = 4'hF
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // ADD..RSC occupy the bottom of the map and all produce C/V from the adder.
    function automatic logic is_arith(input logic [3:0] op);
        return op <= OP_RSC;
    endfunction

    // Ops whose adder carry-in is the architectural C flag.
    function automatic logic uses_carry(input logic [3:0] op);
        return (op == OP_ADC) || (op == OP_SBC) || (op == OP_RSC);
    endfunction

    function automatic logic is_defined(input logic [3:0] op);
`ifdef ARM_ALU_MUL_EN
        return op <= OP_MUL;
`else
        return op <= OP_BIC;
`endif
    endfunction

endpackage

// File: rtl/arm_alu_core.sv
// ---------------------------------------------------------------------------
// arm_alu_core
// Purely combinational ALU datapath for every single-cycle opcode.
//   a, b      in  WIDTH  operands
//   op        in  4      opcode (alu_op_e)
//   flags_in  in  4      current {N,Z,C,V}; supplies carry-in and C/V passthrough
//   result    out WIDTH  op result (0 for undefined ops and for MUL)
//   flags     out 4      {N,Z,C,V} produced by this op
// MUL is sequenced by the pipeline wrapper; here it looks like an undefined op.
// ---------------------------------------------------------------------------
module arm_alu_core
    import arm_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic [3:0]       flags_in,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic             rev_op;
    logic             sub_op;
    logic             cin;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   sum;

    // Every arithmetic op is x + y + cin; subtraction feeds the inverted
    // subtrahend so the top bit of sum is directly ARM's C (NOT borrow).
    assign rev_op = (op == OP_RSB) || (op == OP_RSC);
    assign sub_op = (op == OP_SUB) || (op == OP_SBC) || rev_op;
    assign x      = rev_op ? b : a;
    assign y      = sub_op ? ~(rev_op ? a : b) : b;
    assign cin    = uses_carry(op) ? flags_in[FLAG_C] : sub_op;
    assign sum    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        result = '0;
        flags  = flags_in;
        case (op)
            OP_ADD, OP_ADC, OP_SUB,
            OP_SBC, OP_RSB, OP_RSC: result = sum[WIDTH-1:0];
            OP_AND:  result = a & b;
            OP_ORR:  result = a | b;
            OP_EOR:  result = a ^ b;
            OP_MOVA: result = a;
            OP_MOVB: result = b;
            OP_MVN:  result = ~b;
            OP_BIC:  result = a & ~b;
            default: result = '0;
        endcase

        if (is_defined(op) && (op != OP_MUL)) begin
            flags[FLAG_N] = result[WIDTH-1];
            flags[FLAG_Z] = (result == '0);
        end
        // With the subtrahend already inverted, add and sub share one overflow
        // rule: addends agree in sign and the sum sign differs from them.
        if (is_arith(op)) begin
            flags[FLAG_C] = sum[WIDTH];
            flags[FLAG_V] = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        end
    end

endmodule

// File: rtl/arm_alu_pipe.sv
// ---------------------------------------------------------------------------
// arm_alu_pipe
// Two-stage (E: operands + compute, O: result registers) ALU with valid/ready
// handshakes on both sides and an architectural NZCV register.
//   clk, reset           clock; synchronous active-high reset
//   in_valid / in_ready  input handshake; a, b, op, set_flags ride with it
//   out_valid/out_ready  output handshake; result, out_flags ride with it
//   flags_q              architectural {N,Z,C,V}, written as an op leaves E
// Configuration macro: ARM_ALU_MUL_EN adds a WIDTH-cycle shift-add MUL (1101).
// ---------------------------------------------------------------------------
module arm_alu_pipe
    import arm_alu_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       out_flags,
    output logic [3:0]       flags_q
);

    logic             e_valid;
    logic [WIDTH-1:0] e_a;
    logic [WIDTH-1:0] e_b;
    logic [3:0]       e_op;
    logic             e_set_flags;
    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;
    logic [WIDTH-1:0] e_result;
    logic [3:0]       e_flags;
    logic             e_done;
    logic             e_advance;
    logic             accept;

    arm_alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (e_a),
        .b        (e_b),
        .op       (e_op),
        .flags_in (flags_q),
        .result   (core_result),
        .flags    (core_flags)
    );

`ifdef ARM_ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);

    logic             e_is_mul;
    logic             mul_last;
    logic [CNT_W-1:0] mul_cnt;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_sum;

    // e_a shifts left and e_b right each iteration, so every step adds the
    // current e_a when the current LSB of e_b is set. The last of the WIDTH
    // steps is taken combinationally on the edge that moves the op into O.
    assign e_is_mul = (e_op == OP_MUL);
    assign mul_last = (mul_cnt == CNT_W'(WIDTH - 1));
    assign mul_sum  = mul_acc + (e_b[0] ? e_a : '0);
    assign e_done   = !e_is_mul || mul_last;

    always_comb begin
        e_result = core_result;
        e_flags  = core_flags;
        if (e_is_mul) begin
            e_result       = mul_sum;
            e_flags[FLAG_N] = mul_sum[WIDTH-1];
            e_flags[FLAG_Z] = (mul_sum == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || e_advance) begin
            mul_cnt <= '0;
            mul_acc <= '0;
        end else if (e_valid && e_is_mul && !mul_last) begin
            mul_cnt <= mul_cnt + CNT_W'(1);
            mul_acc <= mul_sum;
        end
    end
`else
    assign e_done   = 1'b1;
    assign e_result = core_result;
    assign e_flags  = core_flags;
`endif

    // E moves on when its op is finished and O is empty or draining this edge.
    assign e_advance = e_valid && e_done && (!out_valid || out_ready);
    assign in_ready  = !e_valid || e_advance;
    assign accept    = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_valid   <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            out_flags <= '0;
            flags_q   <= FLAG_RESET;
        end else begin
            if (accept) begin
                e_valid <= 1'b1;
            end else if (e_advance) begin
                e_valid <= 1'b0;
            end

            if (e_advance) begin
                out_valid <= 1'b1;
                result    <= e_result;
                out_flags <= e_flags;
                // Committing here means the op that enters E on this same edge
                // already computes against the updated C.
                if (e_set_flags && is_defined(e_op)) begin
                    flags_q <= e_flags;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // NOTE: the E payload has no reset; e_valid alone qualifies it, so stale
    // contents after reset are never observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            e_a         <= a;
            e_b         <= b;
            e_op        <= op;
            e_set_flags <= set_flags;
        end
`ifdef ARM_ALU_MUL_EN
        else if (e_valid && e_is_mul && !mul_last) begin
            e_a <= e_a << 1;
            e_b <= e_b >> 1;
        end
`endif
    end

endmodule

// File: tb/tb_arm_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_arm_alu_pipe
// Directed bench for arm_alu_pipe (WIDTH=32). Expected results come from an
// independent 64-bit reference model, are queued when an op is offered, and
// are popped and compared whenever the DUT hands a result out.
// ---------------------------------------------------------------------------
module tb_arm_alu_pipe;
    import arm_alu_pkg::*;

    localparam logic [3:0] FLAG_RST = 4'b0000;
    localparam longint     S_MAX    = 64'sh0000_0000_7FFF_FFFF;
    localparam longint     S_MIN    = -64'sh0000_0000_8000_0000;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        set_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  out_flags;
    logic [3:0]  flags_q;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [3:0]  mf;
    int          n_assert = 0;
    int          n_fail   = 0;

    arm_alu_pipe #(.WIDTH(32), .FLAG_RESET(FLAG_RST)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .set_flags (set_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_flags (out_flags),
        .flags_q   (flags_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic is_def(input logic [3:0] o);
`ifdef ARM_ALU_MUL_EN
        return o <= 4'hD;
`else
        return o <= 4'hC;
`endif
    endfunction

    // Reference model: signed/unsigned 64-bit arithmetic, V from range check.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic [3:0] f);
        exp_t            r;
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint unsigned ci = f[1] ? 1 : 0;
        longint unsigned nu = f[1] ? 0 : 1;
        longint          sx = $signed(x);
        longint          sy = $signed(y);
        longint          cs = f[1] ? 1 : 0;
        longint          ns = f[1] ? 0 : 1;
        longint          st = 0;
        longint unsigned ut = 0;
        logic            c  = 1'b0;
        r.res = '0;
        r.fl  = f;
        case (o)
            4'h0: begin st = sx + sy;      ut = ux + uy;      c = ut[32]; end
            4'h1: begin st = sx + sy + cs; ut = ux + uy + ci; c = ut[32]; end
            4'h2: begin st = sx - sy;      c = (ux >= uy);      end
            4'h3: begin st = sx - sy - ns; c = (ux >= uy + nu); end
            4'h4: begin st = sy - sx;      c = (uy >= ux);      end
            4'h5: begin st = sy - sx - ns; c = (uy >= ux + nu); end
            4'h6: r.res = x & y;
            4'h7: r.res = x | y;
            4'h8: r.res = x ^ y;
            4'h9: r.res = x;
            4'hA: r.res = y;
            4'hB: r.res = ~y;
            4'hC: r.res = x & ~y;
`ifdef ARM_ALU_MUL_EN
            4'hD: begin ut = ux * uy; r.res = ut[31:0]; end
`endif
            default: r.res = '0;
        endcase
        if (o <= 4'h5) begin
            r.res   = st[31:0];
            r.fl[1] = c;
            r.fl[0] = (st > S_MAX) || (st < S_MIN);
        end
        if (is_def(o)) begin
            r.fl[3] = r.res[31];
            r.fl[2] = (r.res == 32'd0);
        end
        return r;
    endfunction

    function automatic void push_exp(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                     input logic sf);
        exp_t e;
        e = model(o, x, y, mf);
        sb.push_back(e);
        if (sf && is_def(o)) mf = e.fl;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one op, wait (bounded) for in_ready, and hold until it transfers.
    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic sf);
        int n = 0;
        in_valid = 1'b1; op = o; a = x; b = y; set_flags = sf;
        #1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("accept_wait", 32'(in_ready), 32'd1);
        push_exp(o, x, y, sf);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        sb.delete();
        mf = FLAG_RST;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_flags_q", 32'(flags_q), 32'(FLAG_RST));
        reset = 1'b0;
    endtask

    // Output-side scoreboard: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            check("unexpected_output", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("out_result", result, mon_e.res);
                check("out_flags", 32'(out_flags), 32'(mon_e.fl));
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; set_flags = 1'b0;
        out_ready = 1'b1; mf = FLAG_RST;
        tick();
        apply_reset();
        tick();

        // ADD then back-to-back SUB / ADC: forwarded C reaches ADC.
        send(OP_ADD, 32'h9C000038, 32'h70000003, 1'b1);
        check("add_not_yet_out", 32'(out_valid), 32'd0);
        check("add_flags_pending", 32'(flags_q), 32'h0);
        send(OP_SUB, 32'h9C000038, 32'h70000003, 1'b1);
        check("add_latency", 32'(out_valid), 32'd1);
        check("add_result", result, 32'h0C00003B);
        check("add_flags_q", 32'(flags_q), 32'b0010);
        send(OP_ADC, 32'h9C000038, 32'h70000003, 1'b0);
        check("sub_result", result, 32'h2C000035);
        check("sub_out_flags", 32'(out_flags), 32'b0011);
        drain();
        check("sub_flags_q", 32'(flags_q), 32'b0011);

        // Logic ops with C/V passthrough from flags_q = 0011.
        send(OP_AND, 32'h9C000038, 32'h70000003, 1'b0);
        send(OP_BIC, 32'h9C000038, 32'h70000003, 1'b0);
        send(OP_MVN, 32'h9C000038, 32'h70000003, 1'b0);
        drain();
        check("mvn_result", result, 32'h8FFFFFFC);
        check("mvn_out_flags", 32'(out_flags), 32'b1011);
        check("logic_flags_q", 32'(flags_q), 32'b0011);

        // Undefined op with set_flags must not touch flags_q.
        send(OP_UND0, 32'h12345678, 32'h0, 1'b1);
        drain();
        check("und_result", result, 32'd0);
        check("und_flags_q", 32'(flags_q), 32'b0011);

        // Backpressure: two ADDs fill the pipe, the third waits.
        out_ready = 1'b0;
        send(OP_ADD, 32'h00000001, 32'h00000002, 1'b0);
        send(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b1; op = OP_ADD; a = 32'hFFFFFFFF; b = 32'h00000001; set_flags = 1'b0;
        push_exp(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_result", result, sb[0].res);
        end
        out_ready = 1'b1;
        #1;
        check("bp_drain_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        drain();

        // Mixed ops, random operands, occasional one-cycle output stalls.
        for (int i = 0; i < 48; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                out_ready = ($urandom_range(0, 1) == 1);
                tick();
                out_ready = 1'b1;
            end
            send(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        drain();

`ifdef ARM_ALU_MUL_EN
        begin
            int n = 0;
            send(OP_MUL, 32'd3, 32'd5, 1'b0);
            while (!out_valid && n < 100) begin
                if (n < 31) check("mul_in_ready_low", 32'(in_ready), 32'd0);
                tick();
                n++;
            end
            check("mul_latency", 32'(n), 32'd32);
            check("mul_result", result, 32'd15);
            drain();
            send(OP_MUL, 32'd7, 32'd9, 1'b0);
            repeat (9) tick();
            check("mul_busy_before_reset", 32'(out_valid), 32'd0);
            apply_reset();
            repeat (40) tick();
            check("mul_after_reset_idle", 32'(out_valid), 32'd0);
        end
`else
        send(OP_MUL, 32'd3, 32'd5, 1'b1);
        drain();
        check("nomul_result", result, 32'd0);
`endif

        // Reset with both stages full: everything in flight is dropped.
        out_ready = 1'b0;
        send(OP_ORR, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1);
        send(OP_SUB, 32'h00000000, 32'h00000001, 1'b1);
        apply_reset();
        out_ready = 1'b1;
        repeat (3) tick();
        check("post_reset_idle", 32'(out_valid), 32'd0);
        send(OP_RSB, 32'h00000005, 32'h00000003, 1'b1);
        drain();
        check("post_reset_flags_q", 32'(flags_q), 32'(mf));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
